// File: rtl/ifu_fetch_unit_pkg.sv
// ifu_fetch_unit_pkg: shared widths, constants and fetch-state encoding for the IFU
package ifu_fetch_unit_pkg;
    localparam int XLEN = 32;
    localparam int EXU_TO_IFU_BUS_W = XLEN + 1;
    localparam int IFU_TO_IDU_BUS_W = 2 * XLEN;
    localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;
    localparam logic [1:0] RESP_OKAY = 2'b00;
    typedef enum logic [1:0] {
        FETCH_AR = 2'd0,
        WAIT_R   = 2'd1,
        HOLD     = 2'd2,
        WAIT_EXU = 2'd3
    } fetch_state_t;
endpackage

// File: rtl/ifu_fetch_unit_if.sv
// ifu_fetch_unit_if: AXI4-Lite read channel (AR + R) between a reader and the arbiter
// master: drives araddr/arvalid/rready; slave: drives arready/rdata/rresp/rvalid
interface ifu_fetch_unit_if #(parameter int DATA_WIDTH = 32);
    logic [DATA_WIDTH-1:0] araddr;
    logic                  arvalid;
    logic                  arready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;
    modport master(output araddr, arvalid, rready, input arready, rdata, rresp, rvalid);
    modport slave(input araddr, arvalid, rready, output arready, rdata, rresp, rvalid);
endinterface

// File: rtl/ifu_axil_rd_fsm.sv
// ifu_axil_rd_fsm: single-outstanding AXI4-Lite read engine with start/done/rdata/err
// clk, rst_n (async active-low); bus: AXI4-Lite read master; start: begin a read when idle;
// addr: read address, held stable by the caller; ar_done/done: AR/R handshake strobes;
// rdata/err: response data and non-OKAY flag, valid with done
module ifu_axil_rd_fsm
    import ifu_fetch_unit_pkg::*;
#(
    parameter int DATA_WIDTH = XLEN
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ifu_fetch_unit_if.master      bus,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] addr,
    output logic                  ar_done,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  err
);
    logic arvalid_q;
    logic rready_q;
    assign bus.araddr  = addr;
    assign bus.arvalid = arvalid_q;
    assign bus.rready  = rready_q;
    assign ar_done     = arvalid_q && bus.arready;
    assign done        = rready_q && bus.rvalid;
    assign rdata       = bus.rdata;
    assign err         = bus.rresp != RESP_OKAY;
    // A new request is taken only while neither channel is busy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
        end else begin
            arvalid_q <= arvalid_q ? !bus.arready : (start && !rready_q);
            rready_q  <= rready_q ? !bus.rvalid : ar_done;
        end
    end
endmodule

// File: rtl/ifu_fetch_unit.sv
// ifu_fetch_unit: fetch stage holding the PC, one instruction in flight over AXI4-Lite
// clk, rst_n (async active-low); isram: AXI4-Lite read master to the arbiter;
// ifu_done: pulse after each R handshake; ifu_to_idu_bus/valid, idu_allowin: {pc, inst} to IDU;
// exu_to_ifu_bus/valid: {taken, nextpc} retire; ifu_err: sticky non-OKAY response flag.
// IFU_PERF_CNT_EN adds perf_fetch_cnt (R handshakes) and perf_stall_cnt (FETCH_AR/WAIT_R cycles).
module ifu_fetch_unit
    import ifu_fetch_unit_pkg::*;
#(
    parameter int                    DATA_WIDTH     = XLEN,
    parameter logic [DATA_WIDTH-1:0] RESET_PC       = RESET_PC_DEF,
    parameter int                    EXU_TO_IFU_BUS = EXU_TO_IFU_BUS_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    ifu_fetch_unit_if.master          isram,
    output logic                      ifu_done,
    output logic [2*DATA_WIDTH-1:0]   ifu_to_idu_bus,
    output logic                      ifu_to_idu_valid,
    input  logic                      idu_allowin,
    input  logic [EXU_TO_IFU_BUS-1:0] exu_to_ifu_bus,
    input  logic                      exu_to_ifu_valid,
    output logic                      ifu_err
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [31:0]               perf_fetch_cnt,
    output logic [31:0]               perf_stall_cnt
`endif
);
    fetch_state_t          state_q, state_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_next, inst_r, rd_rdata;
    logic                  start, retire, rd_ar_done, rd_done, rd_err;
    ifu_axil_rd_fsm #(.DATA_WIDTH(DATA_WIDTH)) u_rd (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (isram),
        .start   (start),
        .addr    (pc_q),
        .ar_done (rd_ar_done),
        .done    (rd_done),
        .rdata   (rd_rdata),
        .err     (rd_err)
    );
    assign ifu_to_idu_bus = {pc_q, inst_r};
    // Retiring in WAIT_EXU launches the next AR straight away, so arvalid rises one cycle later
    assign retire  = state_q == WAIT_EXU && exu_to_ifu_valid;
    assign start   = state_q == FETCH_AR || retire;
    assign pc_next = exu_to_ifu_bus[EXU_TO_IFU_BUS-1] ? exu_to_ifu_bus[DATA_WIDTH-1:0] : pc_q + DATA_WIDTH'(4);
    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH_AR: state_d = rd_ar_done ? WAIT_R : FETCH_AR;
            WAIT_R:   state_d = rd_done ? HOLD : WAIT_R;
            HOLD:     state_d = idu_allowin ? WAIT_EXU : HOLD;
            WAIT_EXU: state_d = exu_to_ifu_valid ? FETCH_AR : WAIT_EXU;
            default:  state_d = FETCH_AR;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= FETCH_AR;
            pc_q             <= RESET_PC;
            inst_r           <= '0;
            ifu_err          <= 1'b0;
            ifu_done         <= 1'b0;
            ifu_to_idu_valid <= 1'b0;
        end else begin
            state_q          <= state_d;
            ifu_done         <= rd_done;
            ifu_to_idu_valid <= state_d == HOLD;
            ifu_err          <= ifu_err || (rd_done && rd_err);
            if (rd_done) inst_r <= rd_err ? DATA_WIDTH'(NOP_INST) : rd_rdata;
            if (retire) pc_q <= pc_next;
        end
    end
`ifdef IFU_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (rd_done && perf_fetch_cnt != '1) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if ((state_q == FETCH_AR || state_q == WAIT_R) && perf_stall_cnt != '1)
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_ifu_fetch_unit.sv
// tb_ifu_fetch_unit: directed fetch transactions with a queue-based scoreboard and monitor
module tb_ifu_fetch_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ifu_done;
    logic [63:0] ifu_to_idu_bus;
    logic        ifu_to_idu_valid;
    logic        idu_allowin = 1'b0;
    logic [32:0] exu_to_ifu_bus = '0;
    logic        exu_to_ifu_valid = 1'b0;
    logic        ifu_err;
    int          tests = 0;
    int          fails = 0;
    int          ar_hs_cnt = 0;
    int          done_cnt = 0;
    logic [31:0] exp_addr_q[$];
    logic [63:0] exp_bus_q[$];

    ifu_fetch_unit_if #(.DATA_WIDTH(32)) isram();

    ifu_fetch_unit dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .isram            (isram),
        .ifu_done         (ifu_done),
        .ifu_to_idu_bus   (ifu_to_idu_bus),
        .ifu_to_idu_valid (ifu_to_idu_valid),
        .idu_allowin      (idu_allowin),
        .exu_to_ifu_bus   (exu_to_ifu_bus),
        .exu_to_ifu_valid (exu_to_ifu_valid),
        .ifu_err          (ifu_err)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic monitor();
        logic [31:0] a;
        logic [63:0] b;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (isram.arvalid && isram.arready) begin
                    ar_hs_cnt++;
                    if (exp_addr_q.size() == 0) check("ar_unexpected", 64'd1, 64'd0);
                    else begin
                        a = exp_addr_q.pop_front();
                        check("araddr", {32'd0, isram.araddr}, {32'd0, a});
                    end
                end
                if (ifu_to_idu_valid && idu_allowin) begin
                    if (exp_bus_q.size() == 0) check("idu_unexpected", 64'd1, 64'd0);
                    else begin
                        b = exp_bus_q.pop_front();
                        check("idu_bus", ifu_to_idu_bus, b);
                    end
                end
                if (ifu_done) done_cnt++;
            end
        end
    endtask

    // One full fetch: AR (optionally stalled), R one cycle after AR, HOLD, then retire
    task automatic fetch(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] resp,
                         input int exp_lat, input int ar_wait, input int hold_wait,
                         input logic spur, input logic taken, input logic [31:0] npc);
        int n = 0;
        logic [31:0] exp_inst;
        exp_inst = (resp == 2'b00) ? data : 32'h0000_0013;
        exp_addr_q.push_back(addr);
        exp_bus_q.push_back({addr, exp_inst});
        while (!isram.arvalid && n < 20) begin
            tick();
            n++;
        end
        check("ar_latency", 64'(n), 64'(exp_lat));
        repeat (ar_wait) begin
            tick();
            check("arvalid_hold", {63'd0, isram.arvalid}, 64'd1);
            check("araddr_stable", {32'd0, isram.araddr}, {32'd0, addr});
        end
        isram.arready = 1'b1;
        tick();
        isram.arready = 1'b0;
        check("arvalid_drop", {63'd0, isram.arvalid}, 64'd0);
        isram.rvalid = 1'b1;
        isram.rdata  = data;
        isram.rresp  = resp;
        tick();
        isram.rvalid = 1'b0;
        isram.rresp  = 2'b00;
        isram.rdata  = 32'hdead_beef;
        check("rready_drop", {63'd0, isram.rready}, 64'd0);
        check("done_pulse", {63'd0, ifu_done}, 64'd1);
        exu_to_ifu_bus   = {1'b1, 32'h1234_5678};
        exu_to_ifu_valid = spur;
        repeat (hold_wait) begin
            check("hold_valid", {63'd0, ifu_to_idu_valid}, 64'd1);
            check("hold_bus", ifu_to_idu_bus, {addr, exp_inst});
            check("hold_no_ar", {63'd0, isram.arvalid}, 64'd0);
            tick();
        end
        check("valid_before_accept", {63'd0, ifu_to_idu_valid}, 64'd1);
        idu_allowin = 1'b1;
        tick();
        idu_allowin      = 1'b0;
        exu_to_ifu_valid = 1'b0;
        check("valid_after_accept", {63'd0, ifu_to_idu_valid}, 64'd0);
        exu_to_ifu_bus   = {taken, npc};
        exu_to_ifu_valid = 1'b1;
        tick();
        exu_to_ifu_valid = 1'b0;
    endtask

    initial begin
        isram.arready = 1'b0;
        isram.rvalid  = 1'b0;
        isram.rdata   = '0;
        isram.rresp   = 2'b00;
        fork
            monitor();
        join_none
        repeat (3) tick();
        check("rst_arvalid", {63'd0, isram.arvalid}, 64'd0);
        check("rst_rready", {63'd0, isram.rready}, 64'd0);
        check("rst_valid", {63'd0, ifu_to_idu_valid}, 64'd0);
        check("rst_done", {63'd0, ifu_done}, 64'd0);
        check("rst_err", {63'd0, ifu_err}, 64'd0);
        check("rst_araddr", {32'd0, isram.araddr}, 64'h8000_0000);
        rst_n = 1'b1;
        fetch(32'h8000_0000, 32'h0010_0093, 2'b00, 1, 0, 0, 1'b0, 1'b0, 32'h0);
        check("err_clear", {63'd0, ifu_err}, 64'd0);
        fetch(32'h8000_0004, 32'h0020_0113, 2'b00, 0, 5, 0, 1'b0, 1'b0, 32'h0);
        fetch(32'h8000_0008, 32'h0030_0193, 2'b00, 0, 0, 3, 1'b1, 1'b1, 32'h8000_0100);
        fetch(32'h8000_0100, 32'h0040_0213, 2'b00, 0, 0, 0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        fetch(32'hFFFF_FFFC, 32'hABCD_0000, 2'b10, 0, 0, 0, 1'b0, 1'b0, 32'h0);
        check("err_set", {63'd0, ifu_err}, 64'd1);
        fetch(32'h0000_0000, 32'h0050_0293, 2'b00, 0, 0, 1, 1'b0, 1'b0, 32'h0);
        check("err_sticky", {63'd0, ifu_err}, 64'd1);
        exp_addr_q.push_back(32'h0000_0004);
        isram.arready = 1'b1;
        tick();
        isram.arready = 1'b0;
        check("abort_rready", {63'd0, isram.rready}, 64'd1);
        isram.rvalid = 1'b1;
        isram.rdata  = 32'h0BAD_0BAD;
        rst_n = 1'b0;
        #1;
        check("abort_arvalid", {63'd0, isram.arvalid}, 64'd0);
        check("abort_rready_low", {63'd0, isram.rready}, 64'd0);
        check("abort_pc", {32'd0, isram.araddr}, 64'h8000_0000);
        check("abort_err", {63'd0, ifu_err}, 64'd0);
        isram.rvalid = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        fetch(32'h8000_0000, 32'h0060_0313, 2'b00, 1, 0, 0, 1'b0, 1'b0, 32'h0);
        tick();
        check("addr_q_empty", 64'(exp_addr_q.size()), 64'd0);
        check("bus_q_empty", 64'(exp_bus_q.size()), 64'd0);
        check("ar_handshakes", 64'(ar_hs_cnt), 64'd8);
        check("done_pulses", 64'(done_cnt), 64'd7);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ifu_fetch_unit.md
Name: ifu_fetch_unit

Overview:
- Instruction fetch stage directly upstream of the IDU/EXU chain in the multi-cycle NPC core.
- Holds the PC and fetches one instruction at a time over an AXI4-Lite read channel, which goes through the shared arbiter.
- Hands each {pc, inst} to the IDU with a valid/allowin handshake.
- Waits for the EXU redirect/next-PC bus before fetching again; only one instruction is in flight at a time.

Parameters:
- DATA_WIDTH, 32, width of PC, address and instruction.
- RESET_PC, 32'h8000_0000, PC value loaded on reset.
- EXU_TO_IFU_BUS, 33, width of the EXU bus: {taken, nextpc}.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous, active-low reset.
- isram_araddr  output  DATA_WIDTH  fetch address, equal to pc.
- isram_arvalid  output  1  AR valid.
- isram_arready  input  1  AR ready.
- isram_rdata  input  DATA_WIDTH  instruction word.
- isram_rresp  input  2  read response; 2'b00 is OKAY.
- isram_rvalid  input  1  R valid.
- isram_rready  output  1  R ready.
- ifu_done  output  1  one-cycle pulse on the R handshake, to the arbiter.
- ifu_to_idu_bus  output  2*DATA_WIDTH  {pc, inst}.
- ifu_to_idu_valid  output  1  instruction valid.
- idu_allowin  input  1  IDU accepts the instruction.
- exu_to_ifu_bus  input  EXU_TO_IFU_BUS  {taken, nextpc}.
- exu_to_ifu_valid  input  1  EXU has retired the current instruction.
- ifu_err  output  1  sticky flag: a fetch returned a non-OKAY response.

Behaviour:
- Reset (async assert, sync release): state=FETCH_AR, pc=RESET_PC, inst_r=0, ifu_err=0.
- Reset values of the other outputs: isram_arvalid=0, isram_rready=0, ifu_to_idu_valid=0, ifu_done=0.
- Registered outputs: arvalid, rready, valid and done are registered. The first arvalid rises in the first cycle after rst_n deasserts.
- States: FETCH_AR, WAIT_R, HOLD, WAIT_EXU.
- FETCH_AR:
  - arvalid=1, araddr=pc.
  - On arvalid&&arready, go to WAIT_R and drop arvalid the next cycle.
  - arvalid never drops before the handshake; araddr stays stable while arvalid=1.
- WAIT_R:
  - rready=1.
  - On rvalid&&rready, latch inst_r=rdata, pulse ifu_done, and go to HOLD.
  - rready falls the cycle after the handshake.
  - If rresp!=0: inst_r=32'h0000_0013 (nop), ifu_err is set and stays set until reset.
- HOLD:
  - ifu_to_idu_valid=1; the bus carries {pc, inst_r}.
  - On idu_allowin, go to WAIT_EXU; valid is low from the next cycle.
- WAIT_EXU:
  - On exu_to_ifu_valid: pc = taken ? nextpc : pc+4, then go to FETCH_AR.
  - Fetch latency from retire to the next arvalid is 1 cycle.
- pc+4 wraps modulo 2^32.
- nextpc is used as given. IFU does no alignment check.
- exu_to_ifu_valid in any state other than WAIT_EXU is ignored.
- arready asserted before arvalid: the handshake happens only in the cycle where both are high.
- rvalid arriving in the same cycle that rready is first driven: the handshake completes that cycle.
- Reset asserted mid-transaction: the FSM returns to FETCH_AR immediately and any pending response is dropped. The interconnect is reset on the same rst_n.

Optional Feature:
- Macro: IFU_PERF_CNT_EN.
- When defined, adds output perf_fetch_cnt[31:0], which counts R handshakes.
- When defined, adds output perf_stall_cnt[31:0], which counts cycles spent in FETCH_AR or WAIT_R.
- Both counters reset to 0, saturate at 32'hFFFF_FFFF, and are read by the simulation harness.
- When not defined, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Shared package (npc header) holds:
  - EXU_TO_IFU_BUS and IFU_TO_IDU_BUS widths;
  - RESET_PC;
  - NOP_INST = 32'h0000_0013;
  - RESP_OKAY = 2'b00;
  - fetch-state encoding FETCH_AR=2'd0, WAIT_R=2'd1, HOLD=2'd2, WAIT_EXU=2'd3.
- One natural sub-module, ifu_axil_rd_fsm: the AR/R handshake engine with a start/done/rdata/err interface. It is reusable by the LSU read path.
- PC/next-PC logic and the IDU handshake stay in the top.

Test Plan:
- Reset release, with arready=1 and rvalid one cycle after AR:
  - arvalid=1 with araddr=0x80000000 in cycle 1;
  - ifu_to_idu_bus={0x80000000, rdata};
  - ifu_done pulses once.
- arready held low for 5 cycles: arvalid stays 1 and araddr stays stable throughout; exactly one AR handshake occurs.
- idu_allowin held low 3 cycles in HOLD: valid and the bus stay stable, and no new arvalid is issued.
- exu_to_ifu_bus={1, 0x80000100}: the next araddr is 0x80000100.
- exu_to_ifu_bus={0, x} with pc=0x80000004: the next araddr is 0x80000008.
- pc=0xFFFFFFFC with not-taken retire: the next araddr is 0x00000000.
- rresp=2'b10: the instruction delivered is 0x00000013 and ifu_err=1 persists.
- rst_n pulsed low during WAIT_R: arvalid=0 and rready=0 immediately, pc=0x80000000, and a fresh fetch follows.
